// File: rtl/mem_pkg.sv
// Shared MEM-stage memory definitions: FSM state encoding and bus widths.
package mem_pkg;

    localparam int unsigned DATA_W            = 32;
    localparam int unsigned DQ_W              = 16;
    localparam int unsigned ADDR_BASE_DEFAULT = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Phase wait-state counter: counts 0..WAIT_CYCLES-1 and flags the last cycle of a phase.
module sram_wait_counter #(
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last_c = (count == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// MEM-stage data memory responder: serves 32-bit requests as two 16-bit SRAM phases.
// Optional SRAM_ADDR_CHECK_EN adds addr_err and rejects out-of-range addresses.
module sram_controller
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BASE   = ADDR_BASE_DEFAULT,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [DATA_W-1:0]  address,
    input  logic [DATA_W-1:0]  write_data,
    output logic [DATA_W-1:0]  read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DQ_W-1:0]    sram_dq_out,
    input  logic [DQ_W-1:0]    sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
`ifdef SRAM_ADDR_CHECK_EN
    ,
    output logic               addr_err
`endif
);

    localparam int unsigned WORD_AW = SRAM_AW - 1;
    localparam int unsigned CNT_W   = 4;

    state_t              state;
    logic                op_wr;
    logic [WORD_AW-1:0]  word_q;
    logic [DQ_W-1:0]     wdata_hi;

    logic                req_c;
    logic                last_c;
    logic                phase_change_c;
    logic [DATA_W-1:0]   offset_c;
    logic [WORD_AW-1:0]  word_c;

    assign req_c    = wr_en | rd_en;
    assign offset_c = address - DATA_W'(ADDR_BASE);
    assign word_c   = WORD_AW'(offset_c >> 2);

`ifdef SRAM_ADDR_CHECK_EN
    logic bad_addr_c;
    assign bad_addr_c = (address < DATA_W'(ADDR_BASE)) ||
                        ((offset_c >> (2 + WORD_AW)) != '0);
`endif

    // Counter restarts at every phase boundary so each phase lasts WAIT_CYCLES.
    assign phase_change_c = ((state == IDLE) && req_c) ||
                            (((state == LO) || (state == HI)) && last_c);

    sram_wait_counter #(
        .CNT_W       (CNT_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clk    (clk),
        .rst    (rst),
        .clr    (phase_change_c),
        .en     ((state == LO) || (state == HI)),
        .last_c (last_c)
    );

    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = ~req_c;
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Sequencer: SRAM pins are registered and set up one edge ahead of each phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_wr       <= 1'b0;
            word_q      <= '0;
            wdata_hi    <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
`ifdef SRAM_ADDR_CHECK_EN
            addr_err    <= 1'b0;
`endif
        end else begin
`ifdef SRAM_ADDR_CHECK_EN
            addr_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_c) begin
                        op_wr    <= wr_en;
                        word_q   <= word_c;
                        wdata_hi <= write_data[DATA_W-1:DQ_W];
`ifdef SRAM_ADDR_CHECK_EN
                        if (bad_addr_c) begin
                            state    <= DONE;
                            addr_err <= 1'b1;
                            if (!wr_en) begin
                                read_data <= '0;
                            end
                        end else begin
`endif
                            state     <= LO;
                            sram_addr <= {word_c, 1'b0};
                            if (wr_en) begin
                                sram_dq_out <= write_data[DQ_W-1:0];
                                sram_dq_oe  <= 1'b1;
                                sram_we_n   <= 1'b0;
                            end else begin
                                sram_dq_oe  <= 1'b0;
                                sram_we_n   <= 1'b1;
                            end
`ifdef SRAM_ADDR_CHECK_EN
                        end
`endif
                    end
                end
                LO: begin
                    if (last_c) begin
                        state     <= HI;
                        sram_addr <= {word_q, 1'b1};
                        if (op_wr) begin
                            sram_dq_out <= wdata_hi;
                        end else begin
                            read_data[DQ_W-1:0] <= sram_dq_in;
                        end
                    end
                end
                HI: begin
                    if (last_c) begin
                        state      <= DONE;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        if (!op_wr) begin
                            read_data[DATA_W-1:DQ_W] <= sram_dq_in;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed scoreboard bench for sram_controller with a behavioural 16-bit SRAM.
module tb_sram_controller;

    localparam int unsigned AW = 18;
    localparam int WC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [31:0]   address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic [15:0]   sram_dq_in;
    logic          sram_dq_oe;
    logic          sram_we_n;
`ifdef SRAM_ADDR_CHECK_EN
    logic          addr_err;
`endif

    always #5 clk = ~clk;

    sram_controller #(
        .ADDR_BASE   (1024),
        .SRAM_AW     (AW),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
`ifdef SRAM_ADDR_CHECK_EN
        ,
        .addr_err    (addr_err)
`endif
    );

    // Behavioural SRAM: writes on any clock where the strobe and driver are active.
    bit [15:0] mem [256];
    logic      preload;

    always @(posedge clk) begin
        if (preload) begin
            mem[2] <= 16'h5678;
            mem[3] <= 16'h1234;
        end else if (!sram_we_n && sram_dq_oe) begin
            mem[sram_addr[7:0]] <= sram_dq_out;
        end
    end

    assign sram_dq_in = mem[sram_addr[7:0]];

    typedef struct {
        logic          ready;
        logic          we_n;
        logic          oe;
        logic          chk_addr;
        logic [AW-1:0] addr;
        logic          chk_dq;
        logic [15:0]   dq;
    } cyc_t;

    cyc_t        exp_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] last_rd;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request, held through DONE; expectations are queued before the first edge.
    task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic [AW-1:0] hw,
                          input logic [31:0] exp_rd);
        cyc_t        e;
        logic [31:0] er;
        e = '{ready: 1'b0, we_n: 1'b1, oe: 1'b0, chk_addr: 1'b0, addr: '0, chk_dq: 1'b0, dq: '0};
        exp_q.push_back(e);
        for (int ph = 0; ph < 2; ph++) begin
            for (int k = 0; k < WC; k++) begin
                e.ready    = 1'b0;
                e.we_n     = ~wr;
                e.oe       = wr;
                e.chk_addr = 1'b1;
                e.addr     = AW'(hw + AW'(ph));
                e.chk_dq   = wr;
                e.dq       = (ph == 1) ? wd[31:16] : wd[15:0];
                exp_q.push_back(e);
            end
        end
        e = '{ready: 1'b1, we_n: 1'b1, oe: 1'b0, chk_addr: 1'b0, addr: '0, chk_dq: 1'b0, dq: '0};
        exp_q.push_back(e);
        er = wr ? last_rd : exp_rd;
        rd_q.push_back(er);
        last_rd = er;

        wr_en      = wr;
        rd_en      = rd;
        address    = a;
        write_data = wd;
        for (int c = 0; c < 2 * WC + 2; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("ready@%0h c%0d", a, c), 32'(ready), 32'(e.ready));
            check($sformatf("we_n@%0h c%0d", a, c), 32'(sram_we_n), 32'(e.we_n));
            check($sformatf("oe@%0h c%0d", a, c), 32'(sram_dq_oe), 32'(e.oe));
            if (e.chk_addr) begin
                check($sformatf("sram_addr@%0h c%0d", a, c), 32'(sram_addr), 32'(e.addr));
            end
            if (e.chk_dq) begin
                check($sformatf("dq_out@%0h c%0d", a, c), 32'(sram_dq_out), 32'(e.dq));
            end
            if (c == 2 * WC + 1) begin
                check($sformatf("read_data@%0h", a), read_data, rd_q.pop_front());
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycle(input string tag);
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        check({tag, " ready"}, 32'(ready), 32'd1);
        check({tag, " we_n"}, 32'(sram_we_n), 32'd1);
        check({tag, " oe"}, 32'(sram_dq_oe), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        preload    = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = '0;
        write_data = '0;
        last_rd    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        preload = 1'b0;

        @(negedge clk);
        check("reset ready", 32'(ready), 32'd1);
        check("reset read_data", read_data, 32'd0);
        check("reset sram_addr", 32'(sram_addr), 32'd0);
        check("reset dq_out", 32'(sram_dq_out), 32'd0);
        check("reset oe", 32'(sram_dq_oe), 32'd0);
        check("reset we_n", 32'(sram_we_n), 32'd1);
        @(posedge clk);
        #1;

        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0, 32'h0);
        idle_cycle("after write");
        access(1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'h12345678);
        idle_cycle("after read");

        // Back-to-back: second request accepted from IDLE right after DONE.
        access(1'b1, 1'b0, 32'd1040, 32'hA5A53C3C, 18'd8, 32'h0);
        access(1'b0, 1'b1, 32'd1040, 32'h0, 18'd8, 32'hA5A53C3C);
        idle_cycle("after b2b");

        // Simultaneous read and write requests: the write takes priority.
        access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 18'd4, 32'h0);
        idle_cycle("after both");
        access(1'b0, 1'b1, 32'd1032, 32'h0, 18'd4, 32'hCAFEF00D);
        idle_cycle("after readback");

`ifdef SRAM_ADDR_CHECK_EN
        rd_en   = 1'b1;
        address = 32'd1000;
        @(negedge clk);
        check("err c0 ready", 32'(ready), 32'd0);
        check("err c0 we_n", 32'(sram_we_n), 32'd1);
        check("err c0 oe", 32'(sram_dq_oe), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("err c1 ready", 32'(ready), 32'd1);
        check("err c1 addr_err", 32'(addr_err), 32'd1);
        check("err c1 read_data", read_data, 32'd0);
        check("err c1 we_n", 32'(sram_we_n), 32'd1);
        check("err c1 oe", 32'(sram_dq_oe), 32'd0);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        @(negedge clk);
        check("err c2 addr_err", 32'(addr_err), 32'd0);
        @(posedge clk);
        #1;
        last_rd = '0;
`endif

        // Reset during the HI phase of a write aborts the access.
        wr_en      = 1'b1;
        address    = 32'd1044;
        write_data = 32'h11112222;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("hi we_n", 32'(sram_we_n), 32'd0);
        check("hi oe", 32'(sram_dq_oe), 32'd1);
        check("hi sram_addr", 32'(sram_addr), 32'd11);
        check("hi dq_out", 32'(sram_dq_out), 32'h1111);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort ready", 32'(ready), 32'd1);
        check("abort we_n", 32'(sram_we_n), 32'd1);
        check("abort oe", 32'(sram_dq_oe), 32'd0);
        check("abort read_data", read_data, 32'd0);
        check("abort sram_addr", 32'(sram_addr), 32'd0);
        @(posedge clk);
        #1;
        idle_cycle("after abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Responder side of the MEM-stage data-memory interface: accepts the MEM stage's 32-bit read/write requests and serves them from an external 16-bit-wide SRAM.
- Each word access is two halfword accesses with configurable wait states.
- `ready` is low while an access is in flight; top level uses it to freeze all pipeline registers and PC.

Parameters:
- ADDR_BASE, 1024: byte address mapped to SRAM halfword 0.
- SRAM_AW, 18: SRAM halfword-address width.
- WAIT_CYCLES, 2: cycles each halfword phase is held (legal 1..15).

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous active-high reset
- wr_en  input  1  MEM-stage write request (MEM_W_EN)
- rd_en  input  1  MEM-stage read request (MEM_R_EN)
- address  input  32  byte address (ALU result)
- write_data  input  32  store value (Val_Rm)
- read_data  output  32  loaded word, registered
- ready  output  1  1 = no access pending/complete; 0 = freeze pipeline
- sram_addr  output  SRAM_AW  SRAM halfword address
- sram_dq_out  output  16  data driven to SRAM
- sram_dq_in  input  16  data from SRAM
- sram_dq_oe  output  1  1 = controller drives DQ
- sram_we_n  output  1  active-low SRAM write strobe

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, read_data 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1, wait count 0.
- Address mapping: word = (address - ADDR_BASE) >> 2, 32-bit subtract. Halfword address = {word, half}, truncated to SRAM_AW bits, so it wraps modulo 2^SRAM_AW. address[1:0] ignored.
- FSM states and transitions:
  - IDLE: if wr_en or rd_en, latch op, address and write_data, then go to LO. If both are asserted, the write wins.
  - LO: half = 0. Held WAIT_CYCLES cycles, then go to HI.
  - HI: half = 1. Held WAIT_CYCLES cycles, then go to DONE.
  - DONE: one cycle, then go to IDLE.
- ready is combinational:
  - IDLE: ready = ~(wr_en | rd_en).
  - LO, HI: ready = 0.
  - DONE: ready = 1.
- Latency: request seen in cycle 0 gives ready = 1 in cycle 2*WAIT_CYCLES + 1. With WAIT_CYCLES = 2, that is cycle 5.
- The pipeline holds its request stable while ready = 0. The request is still visible during the DONE cycle and must not restart an access; the next accepted request is the one seen in IDLE.
- Write phases:
  - sram_dq_oe = 1 and sram_we_n = 0 for every cycle of LO and HI.
  - LO drives write_data[15:0]; HI drives write_data[31:16].
  - sram_we_n returns to 1 in DONE.
- Read phases:
  - sram_dq_oe = 0 and sram_we_n = 1.
  - sram_dq_in is captured on the last cycle of LO into read_data[15:0], and on the last cycle of HI into read_data[31:16].
  - read_data is valid from DONE and holds until the next read overwrites it.
- Wait counter counts 0..WAIT_CYCLES-1 and clears on every phase change.
- Reset asserted mid-access: abort; all reset values apply on the next edge. No partial write is completed.

Optional Feature:
- SRAM_ADDR_CHECK_EN defined:
  - Adds output addr_err (1 bit, reset 0).
  - An address below ADDR_BASE, or mapping beyond 2^SRAM_AW halfwords, skips LO/HI and goes IDLE->DONE. No SRAM strobes are issued.
  - For a read, read_data is set to 0.
  - addr_err = 1 for that DONE cycle only.
- Not defined: no addr_err port; all addresses wrap as above.

Decomposition:
- Shared package mem_pkg holds:
  - state enum {IDLE, LO, HI, DONE}
  - ADDR_BASE default
  - data width 32 and SRAM DQ width 16 constants
- One natural sub-module, sram_wait_counter: loadable phase counter producing a last-cycle flag.

Test Plan:
- Write 0xDEADBEEF to 1024, WAIT_CYCLES = 2:
  - sram_addr 0 with DQ 0xBEEF and we_n = 0 for 2 cycles.
  - Then sram_addr 1 with 0xDEAD for 2 cycles.
  - ready = 1 at cycle 5.
- Read from 1028 with the SRAM model returning 0x5678 at halfword 2 and 0x1234 at halfword 3:
  - read_data = 0x12345678 in DONE.
  - sram_we_n stays 1 and sram_dq_oe stays 0 throughout.
- Back-to-back write then read, request held through DONE:
  - Exactly two accesses occur.
  - ready pattern is 0,0,0,0,0,1 then repeats.
- rd_en and wr_en both asserted: a write occurs and read_data is unchanged.
- rst pulsed in HI of a write: next cycle state is IDLE, we_n = 1, oe = 0, read_data = 0.
- With SRAM_ADDR_CHECK_EN, read at 1000:
  - No strobes issued.
  - ready = 1 and addr_err = 1 at cycle 1.
  - read_data = 0.
